// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Used by mem_arbiter and arb_pick; round-robin option is MEM_ARB_RR_EN.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } req_id_e;

  localparam int unsigned MEM_WORDS_DEFAULT = 8192;

  // Word index is adr[31:2]; the low byte-offset bits never select a word.
  function automatic logic in_range(logic [31:0] adr, int unsigned words);
    return {2'b00, adr[31:2]} < words;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Winner selection between the fetch and data requesters.
// MEM_ARB_RR_EN selects round-robin on ties; otherwise data has fixed priority.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
  input  logic last_grant,
  output logic winner
);

`ifdef MEM_ARB_RR_EN
  always_comb begin
    if (i_req && d_req) begin
      winner = (last_grant == DATA) ? FETCH : DATA;
    end else if (d_req) begin
      winner = DATA;
    end else begin
      winner = FETCH;
    end
  end
`else
  // With fixed priority only d_req matters; fetch wins whenever data is idle.
  logic unused_inputs;
  assign unused_inputs = i_req ^ last_grant;
  assign winner        = d_req ? DATA : FETCH;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one single-cycle memory, 3 cycles per transaction.
// Define MEM_ARB_RR_EN for round-robin tie-breaking instead of fixed data priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_adr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_adr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] mem_adr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_e      state_q, state_d;
  req_id_e     win_q, win_d;
  req_id_e     pick;
  logic        pick_raw;
  logic        last_grant;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        i_ack_q, i_ack_d;
  logic        i_err_q, i_err_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic        d_ack_q, d_ack_d;
  logic        d_err_q, d_err_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        hit;
  logic        in_access;

  arb_pick u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_grant (last_grant),
    .winner     (pick_raw)
  );

  assign pick = req_id_e'(pick_raw);

`ifdef MEM_ARB_RR_EN
  logic last_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_q <= FETCH;
    end else if (state_q == IDLE && (i_req || d_req)) begin
      last_q <= pick_raw;
    end
  end

  assign last_grant = last_q;
`else
  assign last_grant = FETCH;
`endif

  assign hit       = in_range(adr_q, MEM_WORDS);
  assign in_access = (state_q == ACCESS);

  // Memory strobes are decoded from the latched request, so they exist only in ACCESS.
  assign mem_adr   = in_access ? adr_q : 32'd0;
  assign mem_read  = in_access && hit && !we_q;
  assign mem_write = in_access && hit && we_q;
  assign mem_wdata = (in_access && we_q) ? wdata_q : 32'd0;

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    we_d      = we_q;
    adr_d     = adr_q;
    wdata_d   = wdata_q;
    i_ack_d   = 1'b0;
    i_err_d   = 1'b0;
    i_rdata_d = i_rdata_q;
    d_ack_d   = 1'b0;
    d_err_d   = 1'b0;
    d_rdata_d = d_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          state_d = ACCESS;
          win_d   = pick;
          if (pick == DATA) begin
            we_d    = d_we;
            adr_d   = d_adr;
            wdata_d = d_wdata;
          end else begin
            we_d    = 1'b0;
            adr_d   = i_adr;
            wdata_d = 32'd0;
          end
        end
      end
      ACCESS: begin
        state_d = RESP;
        if (win_q == DATA) begin
          d_ack_d = 1'b1;
          d_err_d = !hit;
          // An in-range write keeps the previous read data.
          if (!hit) begin
            d_rdata_d = 32'd0;
          end else if (!we_q) begin
            d_rdata_d = mem_rdata;
          end
        end else begin
          i_ack_d   = 1'b1;
          i_err_d   = !hit;
          i_rdata_d = hit ? mem_rdata : 32'd0;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      win_q     <= FETCH;
      we_q      <= 1'b0;
      adr_q     <= 32'd0;
      wdata_q   <= 32'd0;
      i_ack_q   <= 1'b0;
      i_err_q   <= 1'b0;
      i_rdata_q <= 32'd0;
      d_ack_q   <= 1'b0;
      d_err_q   <= 1'b0;
      d_rdata_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      wdata_q   <= wdata_d;
      i_ack_q   <= i_ack_d;
      i_err_q   <= i_err_d;
      i_rdata_q <= i_rdata_d;
      d_ack_q   <= d_ack_d;
      d_err_q   <= d_err_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign i_ack   = i_ack_q;
  assign i_err   = i_err_q;
  assign i_rdata = i_rdata_q;
  assign d_ack   = d_ack_q;
  assign d_err   = d_err_q;
  assign d_rdata = d_rdata_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter MEM_WORDS, default 8192, giving the number of 32-bit words in the shared memory.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have fetch-port inputs i_req (1) and i_adr (32), and fetch-port outputs i_ack (1), i_rdata (32) and i_err (1).
REQ-005 The block SHALL have data-port inputs d_req (1), d_we (1), d_adr (32) and d_wdata (32), and data-port outputs d_ack (1), d_rdata (32) and d_err (1).
REQ-006 The block SHALL have memory-side outputs mem_adr (32), mem_read (1), mem_write (1) and mem_wdata (32), and memory-side input mem_rdata (32, combinational read data).

Function
REQ-007 The block SHALL implement the states IDLE, ACCESS and RESP.
REQ-008 IDLE: if any request is high, the block SHALL pick a winner, latch its address, we and wdata (fetch: we=0), and go to ACCESS; otherwise it SHALL stay in IDLE.
REQ-009 ACCESS: the block SHALL drive mem_adr from the latch for exactly one cycle, with mem_read=!we or mem_write=we, capture mem_rdata into the winner's rdata register at the cycle end, and go to RESP.
REQ-010 RESP: the block SHALL pulse the winner's ack high for exactly one cycle, with rdata and err valid, then go to IDLE.
REQ-011 Latency SHALL be fixed: a request sampled in IDLE at cycle N acks in cycle N+2, giving 3 cycles per transaction.
REQ-012 Handshake: a requester SHALL hold req, adr, we and wdata stable until it samples ack, then drop req at that same edge; a req still high in the following IDLE cycle SHALL be treated as a new request.
REQ-013 mem_read and mem_write SHALL be zero outside ACCESS and SHALL never be high together.
REQ-014 Word index SHALL be adr[31:2]; adr[1:0] SHALL be ignored.
REQ-015 Out of range (adr[31:2] >= MEM_WORDS): in ACCESS, no memory strobe; in RESP, rdata=0 and err=1 together with ack.
REQ-016 A write ack SHALL leave d_rdata unchanged.
REQ-017 Simultaneous i_req and d_req SHALL be resolved per REQ-021/REQ-022; the loser stays pending and SHALL be served in the next transaction.
REQ-018 Requests arriving during ACCESS or RESP SHALL be ignored until IDLE.

Reset
REQ-019 While rst=0 at an edge, the block SHALL clear the state to IDLE, and clear all ack, err, mem_read, mem_write, mem_adr, mem_wdata, i_rdata and d_rdata to 0, and clear the last-grant pointer to "fetch".
REQ-020 Reset in ACCESS or RESP SHALL abort the transaction and issue no ack; a write strobe already high at that edge completes in memory, and this is permitted.

Configuration
REQ-021 With MEM_ARB_RR_EN defined, simultaneous requests SHALL go to the requester not granted last (round-robin), and the last-grant pointer SHALL update on every IDLE->ACCESS transition.
REQ-022 Without MEM_ARB_RR_EN, the data port SHALL always win a tie (fixed priority) and no pointer SHALL be implemented.

Structure
REQ-023 Package mem_arb_pkg SHALL hold the state enum (IDLE/ACCESS/RESP), the requester-id type (FETCH/DATA) and MEM_WORDS_DEFAULT=8192.
REQ-024 The winner selection SHALL be a sub-module arb_pick (inputs i_req, d_req and last grant; output winner id), containing the MEM_ARB_RR_EN logic.
REQ-025 The FSM, latches and response registers SHALL stay in mem_arbiter.

Verification
REQ-026 Fetch only: i_req, i_adr=0x10, mem word 4=0x1234 -> mem_read high with mem_adr=0x10 in cycle N+1, i_ack with i_rdata=0x1234 in N+2, i_err=0.
REQ-027 Data write then read: d_we=1, d_adr=0x3E8, d_wdata=0xCAFE, then read 0x3E8 -> mem_write for one cycle, d_ack; then d_rdata=0xCAFE.
REQ-028 Tie: i_req and d_req rise together, repeated 4 times -> without macro D,I,D,I pattern per pair (D first each time); with MEM_ARB_RR_EN, grants alternate D,I,D,I across all transactions.
REQ-029 Out of range: d_adr=0x8000 (word 8192), read -> no mem strobe, d_ack with d_err=1 and d_rdata=0.
REQ-030 Reset mid-ACCESS: rst=0 during a fetch ACCESS -> no i_ack, all outputs 0 next cycle; a fresh request after release completes normally in 3 cycles.
REQ-031 Assertion: mem_read && mem_write never true, and each ack is high for one cycle only.
